// File: rtl/counter_table_ctrl.sv
// Request-side read-modify-write controller and decay pulse generator for a 256 x 3-bit counter table.
// Latency: handshake at A, table read at A+1, write-back at A+2, response pulse at A+3 (one op per 3 cycles).
// Backpressure: ReqReady is high only in IDLE with no decay pending, so a pending decay holds off new requests.
//
// Ports:
//   Clk, Rest                      clock, synchronous active-low reset
//   ReqValid/ReqReady/ReqAddr/
//   ReqOp/ReqVal                   request handshake (op: 0 inc, 1 dec, 2 set, 3 read)
//   RspValid/RspOld/RspNew         one-cycle response with before/after counter values
//   DecayEn, DecayForce            periodic decay timer enable, immediate decay request
//   Atten, Addr, Wen, Din, Dout    counter table side (Dout is registered read data)
module counter_table_ctrl #(
  parameter int DECAY_PERIOD = 1024
) (
  input  logic       Clk,
  input  logic       Rest,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic [7:0] ReqAddr,
  input  logic [1:0] ReqOp,
  input  logic [2:0] ReqVal,
  output logic       RspValid,
  output logic [2:0] RspOld,
  output logic [2:0] RspNew,
  input  logic       DecayEn,
  input  logic       DecayForce,
  output logic       Atten,
  output logic [7:0] Addr,
  input  logic [2:0] Dout,
  output logic       Wen,
  output logic [2:0] Din
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD    = 2'd1;
  localparam logic [1:0] S_WR    = 2'd2;
  localparam logic [1:0] S_DECAY = 2'd3;

  localparam logic [1:0] OP_INC  = 2'd0;
  localparam logic [1:0] OP_DEC  = 2'd1;
  localparam logic [1:0] OP_SET  = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  localparam logic [15:0] TIMER_LAST = 16'(DECAY_PERIOD - 1);

  logic [1:0]  state_q, state_d;
  logic        pend_q, pend_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  val_q, val_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [2:0]  rsp_old_q, rsp_old_d;
  logic [2:0]  rsp_new_q, rsp_new_d;

  logic        hs;
  logic        timer_wrap;
  logic [2:0]  new_val;

  assign ReqReady = (state_q == S_IDLE) && !pend_q && Rest;
  assign hs       = ReqValid && ReqReady;

  // Saturating update of the value returned by the table.
  always_comb begin
    new_val = Dout;
    case (op_q)
      OP_INC:  new_val = (Dout == 3'd7) ? 3'd7 : Dout + 3'd1;
      OP_DEC:  new_val = (Dout == 3'd0) ? 3'd0 : Dout - 3'd1;
      OP_SET:  new_val = val_q;
      default: new_val = Dout;
    endcase
  end

  // Free-running decay timer; DecayEn low freezes it without clearing.
  always_comb begin
    timer_d    = timer_q;
    timer_wrap = 1'b0;
    if (DecayEn) begin
      if (timer_q == TIMER_LAST) begin
        timer_d    = 16'd0;
        timer_wrap = 1'b1;
      end else begin
        timer_d = timer_q + 16'd1;
      end
    end
  end

  // A new decay event in the DECAY cycle itself is kept, so it is not lost
  // behind the pulse being issued; repeated events before service collapse.
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_DECAY) pend_d = 1'b0;
    if (timer_wrap || DecayForce) pend_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q)  state_d = S_DECAY;
        else if (hs) state_d = S_RD;
      end
      S_RD:    state_d = S_WR;
      S_WR:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    op_d   = op_q;
    val_d  = val_q;
    if (hs) begin
      addr_d = ReqAddr;
      op_d   = ReqOp;
      val_d  = ReqVal;
    end
  end

  always_comb begin
    rsp_vld_d = (state_q == S_WR);
    rsp_old_d = rsp_old_q;
    rsp_new_d = rsp_new_q;
    if (state_q == S_WR) begin
      rsp_old_d = Dout;
      rsp_new_d = new_val;
    end
  end

  // Table-side outputs are gated by Rest so an op caught by reset issues no write.
  always_comb begin
    Atten = Rest && (state_q == S_DECAY);
    Addr  = (Rest && ((state_q == S_RD) || (state_q == S_WR))) ? addr_q : 8'd0;
    Wen   = Rest && (state_q == S_WR) && (op_q != OP_READ);
    Din   = Wen ? new_val : 3'd0;
  end

  assign RspValid = rsp_vld_q;
  assign RspOld   = rsp_old_q;
  assign RspNew   = rsp_new_q;

  always_ff @(posedge Clk) begin
    if (!Rest) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      timer_q   <= 16'd0;
      addr_q    <= 8'd0;
      op_q      <= 2'd0;
      val_q     <= 3'd0;
      rsp_vld_q <= 1'b0;
      rsp_old_q <= 3'd0;
      rsp_new_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      val_q     <= val_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_old_q <= rsp_old_d;
      rsp_new_q <= rsp_new_d;
    end
  end

endmodule

// File: tb/tb_counter_table_ctrl.sv
// Directed bench for counter_table_ctrl with a behavioural 256 x 3-bit counter table.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Expected values are hand-computed from the intended counter behaviour.
module tb_counter_table_ctrl;

  localparam logic [1:0] OP_INC  = 2'd0;
  localparam logic [1:0] OP_DEC  = 2'd1;
  localparam logic [1:0] OP_SET  = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  logic       Clk = 1'b0;
  logic       Rest;
  logic       ReqValid;
  logic       ReqReady;
  logic [7:0] ReqAddr;
  logic [1:0] ReqOp;
  logic [2:0] ReqVal;
  logic       RspValid;
  logic [2:0] RspOld;
  logic [2:0] RspNew;
  logic       DecayEn;
  logic       DecayForce;
  logic       Atten;
  logic [7:0] Addr;
  logic [2:0] Dout;
  logic       Wen;
  logic [2:0] Din;

  logic [2:0] mem [256];
  logic       mem_clr;

  int n_chk = 0;
  int n_bad = 0;
  int excl_viol = 0;

  int last_vld, last_old, last_new, last_rdy;
  int wr_wen, wr_din, wr_addr;

  always #5 Clk = ~Clk;

  counter_table_ctrl #(.DECAY_PERIOD(8)) dut (
    .Clk(Clk), .Rest(Rest),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
    .ReqOp(ReqOp), .ReqVal(ReqVal),
    .RspValid(RspValid), .RspOld(RspOld), .RspNew(RspNew),
    .DecayEn(DecayEn), .DecayForce(DecayForce),
    .Atten(Atten), .Addr(Addr), .Dout(Dout), .Wen(Wen), .Din(Din)
  );

  // Counter table: registered read every cycle, decrement-all on Atten.
  always @(posedge Clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 3'd0;
    end else if (Atten) begin
      for (int i = 0; i < 256; i++) mem[i] <= (mem[i] == 3'd0) ? 3'd0 : mem[i] - 3'd1;
    end else if (Wen) begin
      mem[Addr] <= Din;
    end
    Dout <= mem[Addr];
  end

  always @(posedge Clk) begin
    if (Atten && Wen) excl_viol <= excl_viol + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full request: wait for acceptance, then sample the WR and response cycles.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [2:0] v, input bit frc);
    int k;
    @(negedge Clk);
    ReqValid = 1'b1; ReqOp = op; ReqAddr = a; ReqVal = v;
    #1;
    k = 0;
    while (!ReqReady && k < 20) begin
      @(negedge Clk); #1;
      k++;
    end
    if (!ReqReady) chk("handshake_timeout", 0, 1);
    @(negedge Clk);
    ReqValid = 1'b0;
    @(negedge Clk);
    DecayForce = frc;
    #1;
    wr_wen = Wen; wr_din = Din; wr_addr = Addr;
    @(negedge Clk);
    DecayForce = 1'b0;
    #1;
    last_vld = RspValid; last_old = RspOld; last_new = RspNew; last_rdy = ReqReady;
  endtask

  initial begin
    int c, t1, t2, en, en2;
    Rest = 1'b0; ReqValid = 1'b0; ReqAddr = 8'd0; ReqOp = 2'd0; ReqVal = 3'd0;
    DecayEn = 1'b0; DecayForce = 1'b0; mem_clr = 1'b1;

    // Reset: everything low even with a request offered.
    repeat (3) @(negedge Clk);
    ReqValid = 1'b1;
    #1;
    chk("rst_ReqReady", ReqReady, 0);
    chk("rst_RspValid", RspValid, 0);
    chk("rst_RspOld", RspOld, 0);
    chk("rst_RspNew", RspNew, 0);
    chk("rst_Atten", Atten, 0);
    chk("rst_Addr", Addr, 0);
    chk("rst_Wen", Wen, 0);
    chk("rst_Din", Din, 0);

    @(negedge Clk);
    Rest = 1'b1; ReqValid = 1'b0; mem_clr = 1'b0;
    #1;
    chk("release_ReqReady", ReqReady, 1);

    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk); #1;
      if (Atten || Wen || RspValid) c++;
    end
    chk("idle_quiet", c, 0);

    // Saturation up.
    for (int i = 0; i < 9; i++) begin
      do_op(OP_INC, 8'h12, 3'd0, 1'b0);
      chk($sformatf("inc%0d_vld", i), last_vld, 1);
      chk($sformatf("inc%0d_old", i), last_old, (i > 7) ? 7 : i);
      chk($sformatf("inc%0d_new", i), last_new, (i + 1 > 7) ? 7 : i + 1);
    end

    // Saturation down, set, read.
    do_op(OP_DEC, 8'h00, 3'd0, 1'b0);
    chk("dec0_old", last_old, 0);
    chk("dec0_new", last_new, 0);
    do_op(OP_SET, 8'hFF, 3'd5, 1'b0);
    chk("set5_wen", wr_wen, 1);
    chk("set5_din", wr_din, 5);
    chk("set5_addr", wr_addr, 8'hFF);
    chk("set5_new", last_new, 5);
    do_op(OP_READ, 8'hFF, 3'd0, 1'b0);
    chk("read5_old", last_old, 5);
    chk("read5_new", last_new, 5);
    chk("read5_wen", wr_wen, 0);

    // Back-to-back incs with ReqValid held.
    @(negedge Clk);
    ReqValid = 1'b1; ReqOp = OP_INC; ReqAddr = 8'h40; ReqVal = 3'd0;
    #1; chk("b2b_rdy_a0", ReqReady, 1);
    @(negedge Clk); #1; chk("b2b_rdy_a1", ReqReady, 0);
    @(negedge Clk); #1; chk("b2b_rdy_a2", ReqReady, 0);
    chk("b2b_wen1", Wen, 1);
    chk("b2b_din1", Din, 1);
    chk("b2b_addr1", Addr, 8'h40);
    @(negedge Clk); #1; chk("b2b_rdy_a3", ReqReady, 1);
    chk("b2b_vld1", RspValid, 1);
    chk("b2b_old1", RspOld, 0);
    chk("b2b_new1", RspNew, 1);
    @(negedge Clk); ReqValid = 1'b0; #1;
    chk("b2b_rdy_a4", ReqReady, 0);
    chk("b2b_vld_gap", RspValid, 0);
    @(negedge Clk); #1;
    chk("b2b_wen2", Wen, 1);
    chk("b2b_din2", Din, 2);
    @(negedge Clk); #1;
    chk("b2b_vld2", RspValid, 1);
    chk("b2b_old2", RspOld, 1);
    chk("b2b_new2", RspNew, 2);

    // Decay of a single entry.
    do_op(OP_SET, 8'h03, 3'd3, 1'b0);
    chk("set3_new", last_new, 3);
    @(negedge Clk);
    DecayEn = 1'b1;
    #1;
    c = 0;
    while (!Atten && c < 40) begin
      @(negedge Clk); #1;
      c++;
    end
    chk("decay_seen", Atten, 1);
    DecayEn = 1'b0;
    do_op(OP_READ, 8'h03, 3'd0, 1'b0);
    chk("decay_read_old", last_old, 2);
    chk("decay_read_new", last_new, 2);

    // Pulse spacing and request held off in the pending cycle.
    @(negedge Clk);
    DecayEn = 1'b1;
    #1;
    c = 0;
    while (!Atten && c < 40) begin
      @(negedge Clk); #1; c++;
    end
    t1 = c;
    en = Atten;
    @(negedge Clk); #1; c++;
    chk("atten_one_cycle", Atten, 0);
    while (!Atten && c < 80) begin
      @(negedge Clk); #1; c++;
    end
    t2 = c;
    en2 = Atten;
    chk("atten_found", en & en2, 1);
    chk("atten_period", t2 - t1, 8);
    for (int i = 1; i <= 7; i++) begin
      @(negedge Clk);
      if (i == 7) begin
        ReqValid = 1'b1; ReqOp = OP_SET; ReqAddr = 8'h50; ReqVal = 3'd6;
      end
      #1;
    end
    chk("pend_rdy", ReqReady, 0);
    chk("pend_atten", Atten, 0);
    @(negedge Clk); #1;
    chk("pend_pulse", Atten, 1);
    chk("pend_pulse_rdy", ReqReady, 0);
    @(negedge Clk);
    DecayEn = 1'b0;
    #1;
    chk("after_pulse_rdy", ReqReady, 1);
    @(negedge Clk); ReqValid = 1'b0;
    @(negedge Clk);
    @(negedge Clk); #1;
    chk("after_pulse_vld", RspValid, 1);
    chk("after_pulse_old", RspOld, 0);
    chk("after_pulse_new", RspNew, 6);

    // Forced decay during WR runs right after the op.
    do_op(OP_READ, 8'h50, 3'd0, 1'b1);
    chk("force_read_new", last_new, 6);
    chk("force_rsp_vld", last_vld, 1);
    chk("force_rdy_held", last_rdy, 0);
    @(negedge Clk); #1;
    chk("force_atten", Atten, 1);
    chk("force_wen", Wen, 0);
    @(negedge Clk); #1;
    chk("force_done_atten", Atten, 0);
    chk("force_done_rdy", ReqReady, 1);
    chk("force_table", mem[8'h50], 5);

    // Reset during WR of an inc.
    @(negedge Clk);
    ReqValid = 1'b1; ReqOp = OP_INC; ReqAddr = 8'h60; ReqVal = 3'd0;
    #1; chk("rstop_rdy", ReqReady, 1);
    @(negedge Clk); ReqValid = 1'b0;
    @(negedge Clk); Rest = 1'b0; #1;
    chk("rstop_wen", Wen, 0);
    chk("rstop_addr", Addr, 0);
    chk("rstop_din", Din, 0);
    @(negedge Clk); Rest = 1'b1; DecayEn = 1'b1; #1;
    chk("rstop_no_rsp", RspValid, 0);
    chk("rstop_rdy_after", ReqReady, 1);
    c = 0;
    while (!Atten && c < 40) begin
      @(negedge Clk); #1;
      if (RspValid) chk("rstop_late_rsp", RspValid, 0);
      c++;
    end
    chk("rstop_first_atten", c, 9);
    DecayEn = 1'b0;
    chk("rstop_no_write", mem[8'h60], 0);

    @(negedge Clk);
    chk("atten_wen_exclusive", excl_viol, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_table_ctrl.md
# counter_table_ctrl

Request-side controller for the 256-entry, 3-bit counter table (`Counter_256`), the ports that table's client must drive. It accepts update and query requests over a valid/ready handshake. Each request is run as a read-modify-write against the table: read, then saturating compute, then write-back. A response carries the old and new counter values. The block also generates the table's periodic decay pulse (`Atten`) and never lets decay overlap a read-modify-write. It sits between the predictor/replacement logic and the counter table, one instance per table.

## Interface
- `DECAY_PERIOD`, 1024: cycles between automatic decay pulses. Legal range 2..65535.
- `Clk`  in  1  clock; all logic on the rising edge.
- `Rest`  in  1  reset; synchronous, active-low.
- `ReqValid`  in  1  request valid.
- `ReqReady`  out  1  controller can accept a request this cycle.
- `ReqAddr`  in  8  table index.
- `ReqOp`  in  2  operation: 00 = inc, 01 = dec, 10 = set, 11 = read.
- `ReqVal`  in  3  value for set; ignored for other ops.
- `RspValid`  out  1  one-cycle response pulse.
- `RspOld`  out  3  counter value before the op.
- `RspNew`  out  3  counter value after the op (equals `RspOld` for read).
- `DecayEn`  in  1  enables the automatic decay timer.
- `DecayForce`  in  1  one-cycle request for an immediate decay.
- `Atten`  out  1  to table: decrement-all pulse.
- `Addr`  out  8  to table: index.
- `Dout`  in  3  from table: registered read data, valid the cycle after a read cycle.
- `Wen`  out  1  to table: write enable.
- `Din`  out  3  to table: write data.

## Operation
- States:
  - IDLE: accepts requests or starts a decay.
  - RD: table read cycle.
  - WR: data returned, compute, and write-back.
  - DECAY: `Atten` = 1 for one cycle.
- `ReqReady` = (state == IDLE) && !decay_pending && Rest.
- A handshake (`ReqValid` && `ReqReady`) latches `ReqAddr`, `ReqOp` and `ReqVal`, then moves to RD.
- IDLE with decay_pending moves to DECAY, which clears decay_pending and returns to IDLE.
- RD: `Addr` = latched addr, `Wen` = 0, `Atten` = 0. Always goes to WR.
- WR: `Addr` = latched addr. New value is computed from `Dout`:
  - inc: min(`Dout`+1, 7).
  - dec: max(`Dout`-1, 0).
  - set: latched `ReqVal`.
  - read: `Dout`.
  - `Wen` = (op != read), `Din` = new value. Goes to IDLE.
- Response: `RspValid`, `RspOld` (= `Dout`) and `RspNew` are registered at the end of WR.
- Table-side outputs are combinational from state and latched registers. They are 0 in IDLE and while `Rest` = 0. `Addr` holds the latched addr.
- Decay timer: a 16-bit count, incremented each cycle while `DecayEn` = 1.
  - When it reaches `DECAY_PERIOD`-1 it wraps to 0 and sets decay_pending.
  - `DecayForce` also sets decay_pending.
  - Multiple sets before service collapse into one pulse.
  - `DecayEn` = 0 freezes the count; it does not clear it.
- Decay_pending arising mid-op: the op completes first, then DECAY runs. A request in the same IDLE cycle is held off (`ReqReady` = 0).
- Reset:
  - State goes to IDLE; decay_pending, the timer and the latched fields clear.
  - `RspValid`/`RspOld`/`RspNew` go to 0; `ReqReady` = 0; all table-side outputs are 0.
  - An op in flight when reset asserts is dropped with no response and no write.

## Timing
- Cycle A (IDLE): handshake.
- A+1 (RD): table read.
- A+2 (WR): `Dout` valid and write-back.
- A+3 (IDLE): `RspValid` = 1, `ReqReady` = 1 again.
- Throughput: one op per 3 cycles. Back-to-back handshakes occur at A and A+3.
- Same-address back-to-back ops need no bypass. The write at the end of A+2 precedes the next read at A+4.
- Decay costs one cycle (DECAY). The first `Atten` occurs at the earliest `DECAY_PERIOD` cycles after reset release, delayed by at most 3 cycles if an op is in flight.
- `Atten`, `Wen` and a read are mutually exclusive in every cycle.

## Test plan
- Reset release, idle:
  - All outputs are 0 while `Rest` = 0.
  - `ReqReady` = 1 in the first cycle after release.
  - `Atten`, `Wen` and `RspValid` stay 0 with `DecayEn` = 0.
- Saturation up: 9 inc to addr 0x12 from 0 -> `RspNew` = 1,2,...,7,7,7. The 8th response has `RspOld` = 7, `RspNew` = 7.
- Saturation down and set/read:
  - dec at addr 0x00 (value 0) -> `RspOld` = 0, `RspNew` = 0.
  - set 5 to 0xFF, then read 0xFF -> `RspOld` = `RspNew` = 5, `Wen` = 0 during the read's WR.
- Back-to-back: `ReqValid` held, inc addr 0x40 twice -> `ReqReady` pattern 1,0,0,1. Responses (0->1), then (1->2). `Wen`/`Din` = 1/1, then 1/2.
- Decay (`DECAY_PERIOD` = 8, `DecayEn` = 1):
  - `Atten` pulses once every 8 cycles.
  - Set addr 3 to 3, wait for one pulse, read addr 3 -> 2.
  - A request presented in the pending cycle is accepted one cycle after `Atten`.
  - `DecayForce` during WR -> DECAY immediately follows the op.
- Reset mid-op: `Rest` = 0 during WR of an inc -> `Wen` = 0 that cycle, no `RspValid`. After release, state is IDLE and the timer restarts from 0.
